// File: rtl/qfix_to_bcd_if.sv
// ----------------------------------------------------------------------------
// qfix_to_bcd_if : quotient-in / BCD-out signal bundle for qfix_to_bcd
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface qfix_to_bcd_if #(
  parameter int WIDTH   = 31,
  parameter int FBITS   = 16,
  parameter int IDIGITS = 5,
  parameter int FDIGITS = 4
);
  logic                   in_valid;
  logic [WIDTH:0]         in_data;
  logic                   in_warn;
  logic                   busy;
  logic                   out_valid;
  logic                   out_sign;
  logic [4*IDIGITS-1:0]   out_int;
  logic [4*FDIGITS-1:0]   out_frac;
  logic                   out_err;

  modport master (
    output in_valid, in_data, in_warn,
    input  busy, out_valid, out_sign, out_int, out_frac, out_err
  );

  modport slave (
    input  in_valid, in_data, in_warn,
    output busy, out_valid, out_sign, out_int, out_frac, out_err
  );
endinterface

`default_nettype wire

// File: rtl/qfix_to_bcd.sv
// ----------------------------------------------------------------------------
// qfix_to_bcd : sign-magnitude Qm.FBITS word to sign + packed BCD digits
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module qfix_to_bcd #(
  parameter int WIDTH   = 31,
  parameter int FBITS   = 16,
  parameter int IDIGITS = 5,
  parameter int FDIGITS = 4
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  qfix_to_bcd_if.slave  bus
);

  localparam int c_int_bits = WIDTH - FBITS;
  localparam int c_max_cnt  = (c_int_bits > FDIGITS) ? c_int_bits : FDIGITS;
  localparam int c_cnt_w    = $clog2(c_max_cnt) + 1;
  localparam int c_ibcd_w   = 4 * IDIGITS;
  localparam int c_fbcd_w   = 4 * FDIGITS;

  localparam logic [c_cnt_w-1:0] c_int_last  = c_cnt_w'(c_int_bits - 1);
  localparam logic [c_cnt_w-1:0] c_frac_last = c_cnt_w'(FDIGITS - 1);
  localparam logic [FBITS+3:0]   c_ten       = (FBITS+4)'(10);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INT  = 2'd1,
    ST_FRAC = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t                  state_q,    state_d;
  logic [c_cnt_w-1:0]      cnt_q,      cnt_d;
  logic                    sign_q,     sign_d;
  logic                    nz_q,       nz_d;
  logic                    warn_q,     warn_d;
  logic [c_int_bits-1:0]   ishift_q,   ishift_d;
  logic [FBITS-1:0]        frac_q,     frac_d;
  logic [c_ibcd_w-1:0]     ibcd_q,     ibcd_d;
  logic [c_fbcd_w-1:0]     fbcd_q,     fbcd_d;
  logic                    busy_q,     busy_d;
  logic                    ovalid_q,   ovalid_d;
  logic                    osign_q,    osign_d;
  logic [c_ibcd_w-1:0]     oint_q,     oint_d;
  logic [c_fbcd_w-1:0]     ofrac_q,    ofrac_d;
  logic                    oerr_q,     oerr_d;

  logic [c_ibcd_w-1:0]     w_adj;
  logic [FBITS+3:0]        w_prod;

  // Double-dabble correction: any nibble >= 5 would overflow past 9 when doubled.
  for (genvar g = 0; g < IDIGITS; g++) begin : g_adj
    assign w_adj[4*g +: 4] = (ibcd_q[4*g +: 4] >= 4'd5) ? ibcd_q[4*g +: 4] + 4'd3
                                                        : ibcd_q[4*g +: 4];
  end

  assign w_prod = {4'd0, frac_q} * c_ten;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      nz_q     <= 1'b0;
      warn_q   <= 1'b0;
      ishift_q <= '0;
      frac_q   <= '0;
      ibcd_q   <= '0;
      fbcd_q   <= '0;
      busy_q   <= 1'b0;
      ovalid_q <= 1'b0;
      osign_q  <= 1'b0;
      oint_q   <= '0;
      ofrac_q  <= '0;
      oerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
      nz_q     <= nz_d;
      warn_q   <= warn_d;
      ishift_q <= ishift_d;
      frac_q   <= frac_d;
      ibcd_q   <= ibcd_d;
      fbcd_q   <= fbcd_d;
      busy_q   <= busy_d;
      ovalid_q <= ovalid_d;
      osign_q  <= osign_d;
      oint_q   <= oint_d;
      ofrac_q  <= ofrac_d;
      oerr_q   <= oerr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    nz_d     = nz_q;
    warn_d   = warn_q;
    ishift_d = ishift_q;
    frac_d   = frac_q;
    ibcd_d   = ibcd_q;
    fbcd_d   = fbcd_q;
    busy_d   = busy_q;
    ovalid_d = 1'b0;
    osign_d  = osign_q;
    oint_d   = oint_q;
    ofrac_d  = ofrac_q;
    oerr_d   = oerr_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          sign_d   = bus.in_data[WIDTH];
          nz_d     = |bus.in_data[WIDTH-1:0];
          warn_d   = bus.in_warn;
          ishift_d = bus.in_data[WIDTH-1:FBITS];
          frac_d   = bus.in_data[FBITS-1:0];
          ibcd_d   = '0;
          fbcd_d   = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = ST_INT;
        end
      end
      ST_INT: begin
        {ibcd_d, ishift_d} = {w_adj[c_ibcd_w-2:0], ishift_q, 1'b0};
        if (cnt_q == c_int_last) begin
          cnt_d   = '0;
          state_d = ST_FRAC;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_FRAC: begin
        frac_d = w_prod[FBITS-1:0];
        fbcd_d = {fbcd_q[c_fbcd_w-5:0], w_prod[FBITS+3:FBITS]};
        if (cnt_q == c_frac_last) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        oint_d   = ibcd_q;
        ofrac_d  = fbcd_q;
        oerr_d   = warn_q;
        // A zero magnitude is always reported as +0.
        osign_d  = sign_q & nz_q;
        ovalid_d = 1'b1;
        busy_d   = 1'b0;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.busy      = busy_q;
  assign bus.out_valid = ovalid_q;
  assign bus.out_sign  = osign_q;
  assign bus.out_int   = oint_q;
  assign bus.out_frac  = ofrac_q;
  assign bus.out_err   = oerr_q;

endmodule

`default_nettype wire

// File: tb/tb_qfix_to_bcd.sv
// ----------------------------------------------------------------------------
// tb_qfix_to_bcd : randomized and directed checks of qfix_to_bcd
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_qfix_to_bcd;

  localparam int WIDTH   = 31;
  localparam int FBITS   = 16;
  localparam int IDIGITS = 5;
  localparam int FDIGITS = 4;
  localparam int LAT     = 1 + (WIDTH - FBITS) + FDIGITS;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  qfix_to_bcd_if #(.WIDTH(WIDTH), .FBITS(FBITS), .IDIGITS(IDIGITS), .FDIGITS(FDIGITS)) bus ();

  qfix_to_bcd #(.WIDTH(WIDTH), .FBITS(FBITS), .IDIGITS(IDIGITS), .FDIGITS(FDIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: decimal digits straight from the real value, integer by
  // repeated division, fraction digit k = floor(frac * 10^k / 2^FBITS) mod 10.
  function automatic logic [4*IDIGITS-1:0] ref_int(input logic [WIDTH:0] d);
    longint v;
    logic [4*IDIGITS-1:0] r;
    v = longint'(d[WIDTH-1:FBITS]);
    r = '0;
    for (int i = 0; i < IDIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [4*FDIGITS-1:0] ref_frac(input logic [WIDTH:0] d);
    longint f;
    longint p;
    logic [4*FDIGITS-1:0] r;
    f = longint'(d[FBITS-1:0]);
    p = 1;
    r = '0;
    for (int k = 1; k <= FDIGITS; k++) begin
      p = p * 10;
      r[4*(FDIGITS-k) +: 4] = 4'(((f * p) >> FBITS) % 10);
    end
    return r;
  endfunction

  function automatic logic ref_sign(input logic [WIDTH:0] d);
    return d[WIDTH] && (d[WIDTH-1:0] != 0);
  endfunction

  task automatic check_result(input string tag, input logic [WIDTH:0] d, input logic w);
    chk({tag, ".sign"}, 64'(bus.out_sign), 64'(ref_sign(d)));
    chk({tag, ".int"},  64'(bus.out_int),  64'(ref_int(d)));
    chk({tag, ".frac"}, 64'(bus.out_frac), 64'(ref_frac(d)));
    chk({tag, ".err"},  64'(bus.out_err),  64'(w));
  endtask

  // One conversion; optionally drive a second word mid-conversion that must be dropped.
  task automatic convert(input string tag, input logic [WIDTH:0] d, input logic w, input bit inject);
    int n;
    int busy_n;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_warn  = w;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk({tag, ".busy0"}, 64'(bus.busy), 64'd1);
    n = 0;
    busy_n = 0;
    while (1) begin
      if (bus.busy) busy_n++;
      if (inject && n == 4) begin
        bus.in_valid = 1'b1;
        bus.in_data  = ~d;
        bus.in_warn  = ~w;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      n++;
      if (bus.out_valid) break;
      if (n > 3 * LAT) break;
    end
    bus.in_valid = 1'b0;
    chk({tag, ".lat"}, 64'(n), 64'(LAT));
    chk({tag, ".busyn"}, 64'(busy_n), 64'(LAT));
    chk({tag, ".busy1"}, 64'(bus.busy), 64'd0);
    check_result(tag, d, w);
    @(posedge clk);
    #1;
    chk({tag, ".pulse"}, 64'(bus.out_valid), 64'd0);
    check_result({tag, ".hold"}, d, w);
  endtask

  initial begin
    logic [WIDTH:0] d;
    logic [WIDTH:0] d2;
    logic           w;
    int             n;
    int             gap;
    bit             seen;

    total = 0;
    bad   = 0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_warn  = 1'b0;
    rst_n = 1'b0;
    #23;
    chk("rst.busy",  64'(bus.busy),      64'd0);
    chk("rst.valid", 64'(bus.out_valid), 64'd0);
    chk("rst.int",   64'(bus.out_int),   64'd0);
    chk("rst.frac",  64'(bus.out_frac),  64'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    convert("div8_2",  32'h00040000, 1'b0, 1'b0);
    convert("div7_3",  32'h00025555, 1'b0, 1'b0);
    convert("neg6_3",  32'h80020000, 1'b0, 1'b0);
    convert("neg6_n2", 32'h00030000, 1'b0, 1'b0);
    convert("maxpos",  32'h7FFFFFFF, 1'b1, 1'b0);
    chk("maxpos.lit", 64'({bus.out_int, bus.out_frac}), 64'h32767_9999);
    convert("negzero", 32'h80000000, 1'b0, 1'b0);
    convert("drop",    32'h00AB1234, 1'b1, 1'b1);

    for (int i = 0; i < 12; i++) begin
      d = ($urandom & 32'h1) ? 32'($urandom) : {1'b1, 31'($urandom_range(0, 255))};
      w = 1'($urandom);
      convert($sformatf("rnd%0d", i), d, w, 1'b0);
    end

    // Continuous in_valid: second word accepted the edge after DONE, 21-cycle spacing.
    d  = 32'h8123ABCD;
    d2 = 32'h0456F00D;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_warn  = 1'b0;
    @(posedge clk);
    #1;
    bus.in_data = d2;
    bus.in_warn = 1'b1;
    n = 0;
    gap = 0;
    seen = 1'b0;
    while (n < 3 * LAT) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.out_valid) begin
        if (!seen) begin
          seen = 1'b1;
          gap = n;
          check_result("b2b.first", d, 1'b0);
          @(posedge clk);
          #1;
          n++;
          bus.in_valid = 1'b0;
          chk("b2b.accept", 64'(bus.busy), 64'd1);
        end else begin
          gap = n - gap;
          break;
        end
      end
    end
    bus.in_valid = 1'b0;
    chk("b2b.gap", 64'(gap), 64'(LAT + 1));
    check_result("b2b.second", d2, 1'b1);

    // Asynchronous reset part-way through a conversion.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h00123456;
    bus.in_warn  = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst.busy",  64'(bus.busy),      64'd0);
    chk("arst.valid", 64'(bus.out_valid), 64'd0);
    chk("arst.outs",  64'({bus.out_sign, bus.out_err, bus.out_int, bus.out_frac}), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (2 * LAT) begin
      @(posedge clk);
      #1;
      if (bus.out_valid || bus.busy) seen = 1'b1;
    end
    chk("arst.quiet", 64'(seen), 64'd0);
    convert("post_rst", 32'h80097FFF, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/qfix_to_bcd.md
Name: qfix_to_bcd

Overview:
- Downstream stage of the sign-magnitude fixed-point divider (qdiv).
- Captures one quotient word when the divider's valid is seen and converts it to sign plus packed-BCD integer and fraction digits for the display/UART formatting blocks.
- Multi-cycle, one conversion at a time, with a busy/done handshake.
- Integer part uses double-dabble (shift-add-3); fraction uses repeated multiply-by-10.

Parameters:
- WIDTH, 31: magnitude bits of the input word; the sign is bit WIDTH.
- FBITS, 16: fractional bits within the magnitude.
- IDIGITS, 5: integer BCD digits. Must satisfy 10^IDIGITS > 2^(WIDTH-FBITS).
- FDIGITS, 4: fractional BCD digits produced, truncated with no rounding.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  qualifies in_data/in_warn. Connects to the divider's valid.
- in_data  in  WIDTH+1  sign-magnitude Qm.FBITS word. Connects to the divider's quotient.
- in_warn  in  1  divider warn flag, sampled with in_data.
- busy  out  1  conversion in progress; new in_valid is ignored.
- out_valid  out  1  one-cycle pulse when the outputs below are updated.
- out_sign  out  1  1 = negative result.
- out_int  out  4*IDIGITS  packed BCD integer part, most-significant digit at top.
- out_frac  out  4*FDIGITS  packed BCD fraction digits, first digit after the point at top.
- out_err  out  1  latched copy of in_warn for this result.

Behaviour:
Reset:
- Asynchronous on rst_n low, at any time including mid-conversion.
- FSM goes to IDLE; busy=0, out_valid=0, out_sign=0, out_int=0, out_frac=0, out_err=0, all working registers cleared.
- After release, the block waits for a fresh in_valid.

FSM states: IDLE, INT, FRAC, DONE.
- IDLE: on a rising edge with in_valid=1:
  - Latch the sign, integer magnitude in_data[WIDTH-1:FBITS], fraction in_data[FBITS-1:0] and in_warn.
  - Clear the BCD accumulator, set busy=1 and go to INT.
- INT: runs WIDTH-FBITS cycles (15 by default). Each cycle, in this order:
  - Add 3 to every BCD nibble that is >= 5.
  - Shift {bcd, int_shift} left by 1.
  - The counter reaches the end, then go to FRAC.
- FRAC: runs FDIGITS cycles.
  - Each cycle: prod = frac*10, computed FBITS+4 bits wide.
  - The digit is prod[FBITS+3:FBITS], shifted into the low nibble of the fraction accumulator.
  - frac <= prod[FBITS-1:0].
  - After FDIGITS cycles, go to DONE.
- DONE, one cycle:
  - Register out_int, out_frac and out_err.
  - out_sign = latched sign AND (magnitude != 0), so negative zero is reported as +0.
  - Pulse out_valid=1, clear busy and return to IDLE.

Timing and handshake:
- Latency: the accepting edge is edge 0. out_valid is high in the cycle following edge 1+(WIDTH-FBITS)+FDIGITS, i.e. edge 20 with defaults. Total busy time is 20 cycles.
- out_* hold their values between out_valid pulses and are updated only in DONE.
- in_valid while busy=1 is dropped: no queueing, no effect on the current conversion.
- in_valid high continuously: a new word is accepted on the first IDLE edge after DONE. Back-to-back throughput is one conversion per 21 cycles.
- in_valid in the same cycle as DONE is not accepted. It is accepted on the next edge only if it is still high.

Width rules:
- All arithmetic is unsigned on the magnitude.
- No overflow is possible, given the IDIGITS constraint and because FBITS+4 bits hold frac*10.

Test Plan:
- in_data=32'h00040000 (8/2), in_valid pulse -> after 20 edges out_valid=1, out_sign=0, out_int=20'h00004, out_frac=16'h0000.
- in_data=32'h00025555 (7/3) -> out_int=20'h00002, out_frac=16'h3333, out_sign=0.
- in_data=32'h80020000 (-6/3), then 32'h00030000 (-6/-2) -> first out_sign=1, out_int=20'h00002; second out_sign=0, out_int=20'h00003.
- in_data=32'h7FFFFFFF with in_warn=1 -> out_int=20'h32767, out_frac=16'h9999, out_err=1. Then in_data=32'h80000000 -> out_sign=0, out_int=0, out_frac=0, out_err=0.
- Pulse in_valid again 5 cycles after acceptance with different data -> ignored: result matches the first word and busy stays high for exactly 20 cycles.
- Assert rst_n=0 at cycle 8 of a conversion -> busy=0 and all outputs 0 immediately, no out_valid. After release, a new in_valid converts correctly.
